// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel used on both sides of pipe_stage_reg.
// The master drives valid/data/ctrl and the slave drives ready.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 4
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic RV32 pipeline stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Holds a payload and a control bundle under a valid/ready handshake. Supports stall,
// flush, and a saturating stall counter. The control bundle is gated to zero for bubbles.
//
// Build option PIPE_SKID_EN:
//   undefined - single entry; in_ready is combinational (!out_valid | out_ready).
//   defined   - main + skid entry; in_ready is a flop, which cuts the out_ready->in_ready path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  in_if,
  pipe_stage_reg_if.master out_if,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  // Main (output-facing) entry.
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_if.valid & w_in_ready;
  assign w_out_fire = r_main_valid & out_if.ready;

`ifdef PIPE_SKID_EN

  // Skid entry holds the beat accepted while main is full and stalled.
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic              r_in_ready;

  logic              w_main_valid_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;

  assign w_in_ready = r_in_ready;

  // Next-state for both entries: drain main first (refilled from skid), then place the
  // incoming beat behind whatever is still held so acceptance order is preserved.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_main_data_nxt  = r_main_data;
    w_main_ctrl_nxt  = r_main_ctrl;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    w_skid_ctrl_nxt  = r_skid_ctrl;
    if (flush) begin
      // Data registers keep their contents; only the valid bits are squashed.
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      if (w_out_fire) begin
        if (r_skid_valid) begin
          w_main_data_nxt  = r_skid_data;
          w_main_ctrl_nxt  = r_skid_ctrl;
          w_skid_valid_nxt = 1'b0;
        end else begin
          w_main_valid_nxt = 1'b0;
        end
      end
      if (w_in_fire) begin
        if (!w_main_valid_nxt) begin
          w_main_valid_nxt = 1'b1;
          w_main_data_nxt  = in_if.data;
          w_main_ctrl_nxt  = in_if.ctrl;
        end else begin
          w_skid_valid_nxt = 1'b1;
          w_skid_data_nxt  = in_if.data;
          w_skid_ctrl_nxt  = in_if.ctrl;
        end
      end
    end
  end

  // Entry state and registered in_ready (low exactly while the skid entry is occupied).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_main_data  <= w_main_data_nxt;
      r_main_ctrl  <= w_main_ctrl_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_ctrl  <= w_skid_ctrl_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

`else

  // Single entry: a new beat may enter in the same cycle the held beat leaves.
  assign w_in_ready = ~r_main_valid | out_if.ready;

  // Main entry load/drain; flush squashes valid but leaves the payload in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_main_valid <= 1'b1;
      r_main_data  <= in_if.data;
      r_main_ctrl  <= in_if.ctrl;
    end else if (w_out_fire) begin
      r_main_valid <= 1'b0;
    end
  end

`endif

  // Stall counter: counts held-but-blocked cycles, saturates, clear beats increment.
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_if.ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_if.ready  = w_in_ready;
  assign out_if.valid = r_main_valid;
  assign out_if.data  = r_main_data;
  // Bubbles must never carry a live write enable downstream.
  assign out_if.ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue-based reference model checked every cycle.
// A second instance with CNT_W=4 sees identical traffic to exercise counter saturation.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              cnt_clr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_ready;
  logic [15:0]       stall_cnt;
  logic [3:0]        stall_cnt4;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) up4_if ();
  pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dn4_if ();

  assign up_if.valid  = in_valid;
  assign up_if.data   = in_data;
  assign up_if.ctrl   = in_ctrl;
  assign dn_if.ready  = out_ready;
  assign up4_if.valid = in_valid;
  assign up4_if.data  = in_data;
  assign up4_if.ctrl  = in_ctrl;
  assign dn4_if.ready = out_ready;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_if     (up_if),
    .out_if    (dn_if),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_if     (up4_if),
    .out_if    (dn4_if),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt4)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t             m_q[$];
  logic [DATA_W-1:0] m_data;
  int                m_cnt;
  int                m_cnt4;
  bit                m_init = 0;
  bit                seen_aa = 0;

  // Capacity rule: one entry with pass-through, or two entries with a registered ready.
  function automatic logic m_ready();
`ifdef PIPE_SKID_EN
    return m_q.size() < 2;
`else
    return (m_q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge clk) begin
    logic rdy;
    logic held;
    if (reset) begin
      m_q.delete();
      m_data = '0;
      m_cnt  = 0;
      m_cnt4 = 0;
      m_init = 1;
    end else if (m_init) begin
      rdy  = m_ready();
      held = m_q.size() > 0;
      if (cnt_clr) begin
        m_cnt  = 0;
        m_cnt4 = 0;
      end else if (held && !out_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
        m_q.delete();
      end else begin
        if (held && out_ready) void'(m_q.pop_front());
        if (in_valid && rdy) m_q.push_back('{d: in_data, c: in_ctrl});
      end
      if (m_q.size() > 0) m_data = m_q[0].d;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", {63'd0, dn_if.valid}, {63'd0, m_q.size() > 0});
      chk("out_data", dn_if.data, m_data);
      chk("out_ctrl", {60'd0, dn_if.ctrl}, {60'd0, (m_q.size() > 0) ? m_q[0].c : 4'd0});
      chk("in_ready", {63'd0, up_if.ready}, {63'd0, m_ready()});
      chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_cnt));
      chk("stall_cnt4", {60'd0, stall_cnt4}, 64'(m_cnt4));
      chk("out_valid4", {63'd0, dn4_if.valid}, {63'd0, dn_if.valid});
      chk("in_ready4", {63'd0, up4_if.ready}, {63'd0, up_if.ready});
      if (dn_if.valid && dn_if.data == 64'hAA) seen_aa = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", {63'd0, dn_if.valid}, 64'd0);
    chk("rst_out_data", dn_if.data, 64'd0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready", {63'd0, up_if.ready}, 64'd1);

    // 1: single beat then an 8-beat stream at full rate
    in_valid = 1'b1; in_data = 64'h1234; in_ctrl = 4'b1011; out_ready = 1'b1;
    tick();
    chk("t1_valid", {63'd0, dn_if.valid}, 64'd1);
    chk("t1_data", dn_if.data, 64'h1234);
    chk("t1_ctrl", {60'd0, dn_if.ctrl}, 64'hB);
    for (int i = 0; i < 8; i++) begin
      in_data = 64'h100 + 64'(i);
      in_ctrl = 4'(i);
      tick();
      chk("t1_stream", dn_if.data, 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    tick(); tick();

    // 2: five-cycle stall, then counter clear
    in_valid = 1'b1; in_data = 64'h55; in_ctrl = 4'b0110; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("t2_cnt5", {48'd0, stall_cnt}, 64'd5);
    chk("t2_hold", dn_if.data, 64'h55);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t2_clr", {48'd0, stall_cnt}, 64'd0);

    // 4: long stall saturates the 4-bit counter
    repeat (20) tick();
    chk("t4_sat", {60'd0, stall_cnt4}, 64'd15);
    chk("t4_cnt20", {48'd0, stall_cnt}, 64'd20);

    // 3: flush with a held beat and a same-cycle beat 0xAA
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hAA; in_ctrl = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_valid", {63'd0, dn_if.valid}, 64'd0);
    chk("t3_ctrl", {60'd0, dn_if.ctrl}, 64'd0);
    chk("t3_data_kept", dn_if.data, 64'h55);
    chk("t3_in_ready", {63'd0, up_if.ready}, 64'd1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t3_no_aa", {63'd0, seen_aa}, 64'd0);
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;

    // 5: fill both entries under back-pressure, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h1; in_ctrl = 4'h1;
    tick();
    in_data = 64'h2; in_ctrl = 4'h2;
    tick();
    in_valid = 1'b0;
`ifdef PIPE_SKID_EN
    chk("t5_full_ready", {63'd0, up_if.ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("t5_no_comb", {63'd0, up_if.ready}, 64'd0);
    chk("t5_first", dn_if.data, 64'h1);
    tick();
    chk("t5_second", dn_if.data, 64'h2);
    chk("t5_ready_back", {63'd0, up_if.ready}, 64'd1);
`else
    out_ready = 1'b1;
    tick();
`endif
    tick(); tick();

    // 6: reset in the middle of a stall with both entries occupied
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h3; in_ctrl = 4'h3;
    tick();
    in_data = 64'h4; in_ctrl = 4'h4;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6_valid", {63'd0, dn_if.valid}, 64'd0);
    chk("t6_data", dn_if.data, 64'd0);
    chk("t6_ctrl", {60'd0, dn_if.ctrl}, 64'd0);
    chk("t6_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("t6_in_ready", {63'd0, up_if.ready}, 64'd1);
    reset = 1'b0;
    tick();

    // Mixed traffic: irregular valid/ready with a flush and a clear embedded
    for (int i = 0; i < 48; i++) begin
      in_valid  = (i % 3) != 0;
      out_ready = (i % 5) > 1;
      in_data   = 64'h7000 + 64'(i);
      in_ctrl   = 4'(i * 7);
      flush     = (i == 25);
      cnt_clr   = (i == 33);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
